// File: rtl/genius_pkg.sv
// Shared constants, colour/speed codes and playback state encoding for the
// Genius sequence player.
package genius_pkg;

  localparam int SEQ_MAX_LEN = 32;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } colour_t;

  typedef enum logic [1:0] {
    SPD_025 = 2'd0,
    SPD_05  = 2'd1,
    SPD_1   = 2'd2,
    SPD_2   = 2'd3
  } speed_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    SHOW  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic logic [3:0] colour_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/slow_tick_sync.sv
// Brings one slow asynchronous square wave into clk_50MHz and emits a
// single-cycle tick on each of its rising edges.
module slow_tick_sync (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic slow_in,
  output logic tick
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= slow_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tick = s2 & ~prev;

endmodule

// File: rtl/genius_sequence_player.sv
// Plays the stored colour sequence on the LEDs, one tick period on and one
// tick period dark per entry, at the speed latched when playback starts.
//
//   state | meaning
//   IDLE  | waiting for start
//   ALIGN | waiting for first selected tick so colour 0 gets a full period
//   FETCH | rd_addr presented to sequence RAM
//   LOAD  | rd_data valid, colour latched onto led
//   SHOW  | colour lit until next tick
//   GAP   | dark until next tick, then next entry or finish
//   DONE  | one-cycle done pulse, busy drops on the way out
module genius_sequence_player #(
  parameter int SEQ_MAX_LEN = genius_pkg::SEQ_MAX_LEN,
  parameter int ADDR_W      = $clog2(SEQ_MAX_LEN),
  parameter int LEN_W       = ADDR_W + 1
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              clk_025Hz,
  input  logic              clk_05Hz,
  input  logic              clk_1Hz,
  input  logic              clk_2Hz,
  input  logic [1:0]        speed_sel,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  import genius_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SEQ_MAX_LEN);

  logic tick_025;
  logic tick_05;
  logic tick_1;
  logic tick_2;
  logic tick_sel;

  state_t           state_q, state_nxt;
  logic [3:0]       led_q, led_nxt;
  logic             busy_q, busy_nxt;
  logic [LEN_W-1:0] idx_q, idx_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  speed_t           spd_q, spd_nxt;
  logic [LEN_W-1:0] idx_inc;

  slow_tick_sync u_tick_025hz (.clk_50MHz(clk_50MHz), .reset(reset), .slow_in(clk_025Hz), .tick(tick_025));
  slow_tick_sync u_tick_05hz  (.clk_50MHz(clk_50MHz), .reset(reset), .slow_in(clk_05Hz),  .tick(tick_05));
  slow_tick_sync u_tick_1hz   (.clk_50MHz(clk_50MHz), .reset(reset), .slow_in(clk_1Hz),   .tick(tick_1));
  slow_tick_sync u_tick_2hz   (.clk_50MHz(clk_50MHz), .reset(reset), .slow_in(clk_2Hz),   .tick(tick_2));

  // Rate follows the latched speed, not the live speed_sel input.
  always_comb begin
    tick_sel = 1'b0;
    case (spd_q)
      SPD_025: tick_sel = tick_025;
      SPD_05:  tick_sel = tick_05;
      SPD_1:   tick_sel = tick_1;
      SPD_2:   tick_sel = tick_2;
      default: tick_sel = 1'b0;
    endcase
  end

  assign idx_inc = idx_q + LEN_W'(1);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      led_q   <= '0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      spd_q   <= SPD_025;
    end else begin
      state_q <= state_nxt;
      led_q   <= led_nxt;
      busy_q  <= busy_nxt;
      idx_q   <= idx_nxt;
      len_q   <= len_nxt;
      spd_q   <= spd_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    led_nxt   = led_q;
    busy_nxt  = busy_q;
    idx_nxt   = idx_q;
    len_nxt   = len_q;
    spd_nxt   = spd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (seq_len == '0) begin
            state_nxt = DONE;
          end else begin
            len_nxt   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
            spd_nxt   = speed_t'(speed_sel);
            idx_nxt   = '0;
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: if (tick_sel) state_nxt = FETCH;
      FETCH: state_nxt = LOAD;
      LOAD: begin
        led_nxt   = colour_onehot(rd_data);
        state_nxt = SHOW;
      end
      SHOW: begin
        if (tick_sel) begin
          led_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (tick_sel) begin
          if (idx_inc == len_q) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx_inc;
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        led_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = idx_q[ADDR_W-1:0];
  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = (state_q == DONE);

endmodule

// File: doc/genius_sequence_player.md
Name: genius_sequence_player

Overview:
Consumes the free-running slow square waves (0.25/0.5/1/2 Hz) produced by the game's clock-divider block and turns them into single-cycle ticks in the clk_50MHz domain. On a start request it reads the stored colour sequence from sequence memory one entry at a time and plays it on the four colour LEDs. Each colour is shown for one tick period, followed by one tick period dark. It sits between the divider, the sequence RAM and the LED drivers, and is commanded by the top-level game FSM.

Parameters:
SEQ_MAX_LEN, 32, maximum playable sequence length (power of two)
ADDR_W, 5, sequence memory address width, log2(SEQ_MAX_LEN)
LEN_W, 6, width of seq_len, ADDR_W+1

Ports:
clk_50MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_025Hz  in  1  0.25 Hz square wave, asynchronous to clk_50MHz
clk_05Hz  in  1  0.5 Hz square wave, asynchronous
clk_1Hz  in  1  1 Hz square wave, asynchronous
clk_2Hz  in  1  2 Hz square wave, asynchronous
speed_sel  in  2  0=0.25 Hz, 1=0.5 Hz, 2=1 Hz, 3=2 Hz; sampled on accepted start
start  in  1  single-cycle playback request
seq_len  in  LEN_W  number of entries to play; sampled on accepted start
rd_addr  out  ADDR_W  sequence memory read address
rd_data  in  2  colour code; valid exactly 1 cycle after rd_addr (registered RAM)
led  out  4  one-hot colour LEDs: code 0→led[0] green, 1→led[1] red, 2→led[2] yellow, 3→led[3] blue
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when playback completes

Behaviour:
- Reset (synchronous, active-high): outputs led=0, busy=0, done=0, rd_addr=0. State=IDLE. All synchronizer and edge flops=0. Index=0.
- Tick generation, one instance per slow input:
  - Two-flop synchronizer s1→s2, then prev<=s2.
  - tick = s2 & ~prev, high for exactly one cycle.
  - Latency: tick is high in the 2nd cycle after the first clk_50MHz edge that samples the input high.
  - A high input at reset release yields one tick. This is harmless because the FSM is in IDLE.
- Selected tick: the mux is chosen by the speed register latched at start. Changing speed_sel mid-playback has no effect.
- FSM states: IDLE, ALIGN, FETCH, LOAD, SHOW, GAP, DONE.
  - IDLE:
    - start=1 and seq_len=0 → DONE, with busy=1 for that one cycle.
    - start=1 and seq_len≠0 → latch len=min(seq_len,SEQ_MAX_LEN), latch speed, idx=0, busy=1 → ALIGN.
  - ALIGN: wait for a selected tick, then → FETCH. This makes the first colour a full tick period.
  - FETCH: rd_addr=idx for one cycle → LOAD.
  - LOAD: led<=onehot(rd_data) → SHOW.
  - SHOW: hold led. On tick: led<=0 → GAP.
  - GAP: led=0. On tick:
    - if idx+1==len → DONE
    - else idx<=idx+1 → FETCH.
  - DONE: done=1 for one cycle, busy<=0, led=0 → IDLE.
- Timing per entry: colour on for one tick period (plus the 2-cycle fetch/load skew), then off for one tick period. A tick arriving during FETCH/LOAD is ignored. It cannot occur at legal rates.
- start while busy: ignored, with no effect on state or latched values.
- seq_len > SEQ_MAX_LEN: clamped to SEQ_MAX_LEN.
- idx width is LEN_W. rd_addr = idx[ADDR_W-1:0]. idx never exceeds len-1.
- Reset mid-playback: the next cycle is IDLE, led=0, busy=0, and no done pulse.
- busy is deasserted in the same cycle the FSM returns to IDLE, i.e. the cycle after done.

Decomposition:
- Shared package (genius_pkg):
  - colour codes GREEN=0, RED=1, YELLOW=2, BLUE=3
  - speed codes SPD_025=0 .. SPD_2=3
  - FSM state encoding
  - SEQ_MAX_LEN
- One natural sub-module: slow_tick_sync (2-flop synchronizer plus rising-edge detector, synchronous reset), instantiated four times.

Test Plan:
- Tick sync: reset, then drive clk_2Hz low→high once. Required: exactly one tick pulse, 2 cycles after sampling, and none on the falling edge.
- Bench toggles the slow inputs every 20 cycles; speed_sel=3; seq_len=3; memory holds {2,0,3}. Required sequence:
  - led=0100 for one tick period, then 0000
  - then 0001, 0000
  - then 1000, 0000
  - then done pulses once, and busy falls the cycle after done.
- speed_sel=0 versus 3 with the same memory. Required: colour duration = the clk_025Hz period versus the clk_2Hz period. Flipping speed_sel mid-run does not change the rate.
- seq_len=0 with start: done pulses the next cycle, led stays 0, and rd_addr does not advance. seq_len=40: exactly 32 entries are played, with rd_addr 0..31.
- start pulsed again while busy: ignored, and the sequence completes unchanged.
- Assert reset during SHOW of entry 1. Required next cycle: led=0, busy=0, state IDLE, no done. A following start plays from entry 0.
